// File: rtl/qpsk_symbol_scheduler.sv
// QPSK symbol scheduler: streams payload bytes as four (even,odd) symbols each, with underrun filler.
// Optional preamble generation is enabled by defining QPSK_PREAMBLE_EN.
module qpsk_symbol_scheduler #(
    parameter int unsigned SYM_CYCLES  = 52,
    parameter int unsigned FRAME_BYTES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       even,
    output logic       odd,
    output logic       sym_strobe,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SYM_LAST   = CNT_W'(SYM_CYCLES - 1);
    localparam logic [CNT_W-1:0] BYTES_LAST = CNT_W'(FRAME_BYTES);

`ifdef QPSK_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE, PREAMBLE, FETCH, SEND} state_t;
    logic [2:0] pre_cnt, pre_cnt_n;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_n;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_n;
    logic [1:0]       sym_idx, sym_idx_n;
    logic [7:0]       shift_byte, shift_byte_n;
    logic [7:0]       hold_byte, hold_byte_n;
    logic             hold_valid, hold_valid_n;
    logic             filler, filler_n;
    logic             even_n, odd_n, in_ready_n, strobe_n, busy_n, frame_done_n, underrun_n;
    logic             xfer, sym_end;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            byte_cnt   <= '0;
            sym_idx    <= '0;
            shift_byte <= '0;
            hold_byte  <= '0;
            hold_valid <= 1'b0;
            filler     <= 1'b0;
            even       <= 1'b0;
            odd        <= 1'b0;
            in_ready   <= 1'b0;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
`ifdef QPSK_PREAMBLE_EN
            pre_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            cyc_cnt    <= cyc_cnt_n;
            byte_cnt   <= byte_cnt_n;
            sym_idx    <= sym_idx_n;
            shift_byte <= shift_byte_n;
            hold_byte  <= hold_byte_n;
            hold_valid <= hold_valid_n;
            filler     <= filler_n;
            even       <= even_n;
            odd        <= odd_n;
            in_ready   <= in_ready_n;
            sym_strobe <= strobe_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            underrun   <= underrun_n;
`ifdef QPSK_PREAMBLE_EN
            pre_cnt    <= pre_cnt_n;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so they align with it
    always_comb begin
        state_n      = state;
        cyc_cnt_n    = cyc_cnt;
        byte_cnt_n   = byte_cnt;
        sym_idx_n    = sym_idx;
        shift_byte_n = shift_byte;
        hold_byte_n  = hold_byte;
        hold_valid_n = hold_valid;
        filler_n     = filler;
        strobe_n     = 1'b0;
        frame_done_n = 1'b0;
        underrun_n   = 1'b0;
`ifdef QPSK_PREAMBLE_EN
        pre_cnt_n    = pre_cnt;
`endif
        xfer    = in_valid && in_ready;
        sym_end = (cyc_cnt == SYM_LAST);

        if (xfer && (byte_cnt < BYTES_LAST)) begin
            byte_cnt_n = byte_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    cyc_cnt_n    = '0;
                    byte_cnt_n   = '0;
                    sym_idx_n    = '0;
                    hold_valid_n = 1'b0;
                    filler_n     = 1'b0;
`ifdef QPSK_PREAMBLE_EN
                    pre_cnt_n    = '0;
                    strobe_n     = 1'b1;
                    state_n      = PREAMBLE;
`else
                    state_n      = FETCH;
`endif
                end
            end
`ifdef QPSK_PREAMBLE_EN
            PREAMBLE: begin
                cyc_cnt_n = sym_end ? '0 : cyc_cnt + CNT_W'(1);
                if (sym_end) begin
                    if (pre_cnt == 3'd7) begin
                        state_n = FETCH;
                    end else begin
                        pre_cnt_n = pre_cnt + 3'd1;
                        strobe_n  = 1'b1;
                    end
                end
            end
`endif
            FETCH: begin
                if (xfer) begin
                    shift_byte_n = in_data;
                    cyc_cnt_n    = '0;
                    sym_idx_n    = '0;
                    filler_n     = 1'b0;
                    strobe_n     = 1'b1;
                    state_n      = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    hold_byte_n  = in_data;
                    hold_valid_n = 1'b1;
                end
                if (!sym_end) begin
                    cyc_cnt_n = cyc_cnt + CNT_W'(1);
                end else begin
                    cyc_cnt_n = '0;
                    // End of a data symbol within the byte, else a byte/filler boundary
                    if (!filler && (sym_idx != 2'd3)) begin
                        sym_idx_n = sym_idx + 2'd1;
                        strobe_n  = 1'b1;
                    end else if (hold_valid || xfer) begin
                        shift_byte_n = hold_valid ? hold_byte : in_data;
                        hold_valid_n = 1'b0;
                        sym_idx_n    = '0;
                        filler_n     = 1'b0;
                        strobe_n     = 1'b1;
                    end else if (byte_cnt == BYTES_LAST) begin
                        frame_done_n = 1'b1;
                        filler_n     = 1'b0;
                        state_n      = IDLE;
                    end else begin
                        sym_idx_n  = '0;
                        filler_n   = 1'b1;
                        strobe_n   = 1'b1;
                        underrun_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n     = (state_n != IDLE);
        in_ready_n = (state_n == FETCH) ||
                     ((state_n == SEND) && !hold_valid_n && (byte_cnt_n < BYTES_LAST));
        even_n     = 1'b0;
        odd_n      = 1'b0;
        if ((state_n == SEND) && !filler_n) begin
            even_n = shift_byte_n[{sym_idx_n, 1'b0}];
            odd_n  = shift_byte_n[{sym_idx_n, 1'b1}];
        end
`ifdef QPSK_PREAMBLE_EN
        if (state_n == PREAMBLE) begin
            even_n = ~pre_cnt_n[0];
            odd_n  = ~pre_cnt_n[0];
        end
`endif
    end

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Directed bench for qpsk_symbol_scheduler (SYM_CYCLES=4, FRAME_BYTES=3); follows QPSK_PREAMBLE_EN.
module tb_qpsk_symbol_scheduler;

    localparam int unsigned SYM = 4;
    localparam int unsigned FB  = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, even, odd, sym_strobe, busy, frame_done, underrun;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] sym_q[$];
    logic [2:0] exp_q[$];
    int         cyc_q[$];
    int         cyc = 0;
    int         fd_count = 0;
    int         glitch = 0;
    logic [1:0] prev_eo = 2'b00;

    qpsk_symbol_scheduler #(.SYM_CYCLES(SYM), .FRAME_BYTES(FB)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .even(even), .odd(odd), .sym_strobe(sym_strobe), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Symbol capture: every strobe logs (even,odd,underrun); symbol changes without a strobe are errors
    always @(negedge clk) begin
        if (sym_strobe) begin
            sym_q.push_back({even, odd, underrun});
            cyc_q.push_back(cyc);
        end else if (busy && ({even, odd} != prev_eo)) begin
            glitch++;
        end
        if (underrun && !sym_strobe) glitch++;
        prev_eo = {even, odd};
        if (frame_done) fd_count++;
    end

    task automatic clear_capture();
        sym_q.delete(); cyc_q.delete(); exp_q.delete();
        fd_count = 0; glitch = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (fd_count > 0) ok = 1'b1;
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) exp_q.push_back({b[2*k], b[2*k+1], 1'b0});
    endtask

    task automatic add_preamble();
`ifdef QPSK_PREAMBLE_EN
        for (int k = 0; k < 8; k++) exp_q.push_back({~k[0], ~k[0], 1'b0});
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({even, odd, in_ready, sym_strobe, busy, frame_done, underrun} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {even, odd, in_ready, sym_strobe, busy, frame_done, underrun});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, in_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: busy/in_ready got %b want 00", {busy, in_ready});
        end
    endtask

    // Three bytes with in_valid held: 12 gap-free symbols, no underrun, one frame_done
    task automatic test_stream();
        bit ok, all_ok;
        int gaps;
        clear_capture();
        add_preamble(); add_byte(8'hB4); add_byte(8'h1E); add_byte(8'hC3);
        pulse_start();
        all_ok = 1'b1;
        push_byte(8'hB4, ok); all_ok &= ok;
        push_byte(8'h1E, ok); all_ok &= ok;
        push_byte(8'hC3, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        vectors++;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL stream_handshake: got %b want 1", all_ok); end
        vectors++;
        if (sym_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL stream_count: got %0d want %0d", sym_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++) begin
            vectors++;
            if (sym_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL stream_sym%0d: got %b want %b", i, sym_q[i], exp_q[i]);
            end
        end
        gaps = 0;
        for (int i = 1; i < cyc_q.size(); i++) if (cyc_q[i] - cyc_q[i-1] != SYM) gaps++;
        vectors++;
        if (gaps !== 0 || glitch !== 0) begin
            miscompares++; $display("FAIL stream_spacing: gaps %0d glitches %0d want 0 0", gaps, glitch);
        end
        vectors++;
        if ({fd_count == 1, busy, in_ready} !== 3'b100) begin
            miscompares++; $display("FAIL stream_end: frame_done count %0d busy %b in_ready %b want 1 0 0",
                                     fd_count, busy, in_ready);
        end
    endtask

    // Second byte withheld: exactly 10 filler symbols (0,0) each with underrun, then bytes 2 and 3
    task automatic test_underrun();
        bit ok, all_ok;
        int gaps;
        clear_capture();
        add_preamble(); add_byte(8'h5A);
        for (int f = 0; f < 10; f++) exp_q.push_back(3'b001);
        add_byte(8'h96); add_byte(8'h0F);
        pulse_start();
        all_ok = 1'b1;
        push_byte(8'h5A, ok); all_ok &= ok;
        repeat (55) @(posedge clk);
        #1;
        push_byte(8'h96, ok); all_ok &= ok;
        push_byte(8'h0F, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        vectors++;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL underrun_handshake: got %b want 1", all_ok); end
        vectors++;
        if (sym_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL underrun_count: got %0d want %0d", sym_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++) begin
            vectors++;
            if (sym_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL underrun_sym%0d: got %b want %b", i, sym_q[i], exp_q[i]);
            end
        end
        gaps = 0;
        for (int i = 1; i < cyc_q.size(); i++) if (cyc_q[i] - cyc_q[i-1] != SYM) gaps++;
        vectors++;
        if (gaps !== 0 || glitch !== 0 || fd_count !== 1) begin
            miscompares++; $display("FAIL underrun_timing: gaps %0d glitches %0d done %0d want 0 0 1",
                                     gaps, glitch, fd_count);
        end
    endtask

    // Reset during symbol 2 of byte 1 (with start and in_valid also high), then a clean frame
    task automatic test_reset_mid();
        bit ok, all_ok;
        int n;
        clear_capture();
        add_preamble();
        n = exp_q.size() + 3;
        pulse_start();
        push_byte(8'hB4, ok);
        for (int i = 0; i < 200 && sym_q.size() < n; i++) @(negedge clk);
        vectors++;
        if (sym_q.size() !== n) begin
            miscompares++; $display("FAIL midreset_reach: got %0d symbols want %0d", sym_q.size(), n);
        end
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        vectors++;
        if ({even, odd, in_ready, sym_strobe, busy, frame_done, underrun} !== 7'b0) begin
            miscompares++; $display("FAIL midreset_outputs: got %b want 0000000",
                                     {even, odd, in_ready, sym_strobe, busy, frame_done, underrun});
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (30) @(negedge clk);
        vectors++;
        if (fd_count !== 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midreset_quiet: done %0d busy %b want 0 0", fd_count, busy);
        end
        clear_capture();
        add_preamble(); add_byte(8'h3C); add_byte(8'hA5); add_byte(8'h81);
        pulse_start();
        all_ok = 1'b1;
        push_byte(8'h3C, ok); all_ok &= ok;
        push_byte(8'hA5, ok); all_ok &= ok;
        push_byte(8'h81, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        vectors++;
        if (all_ok !== 1'b1 || sym_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL clean_frame: ok %b count %0d want 1 %0d", all_ok, sym_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++) begin
            vectors++;
            if (sym_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL clean_sym%0d: got %b want %b", i, sym_q[i], exp_q[i]);
            end
        end
    endtask

    // start pulses while busy are ignored
    task automatic test_start_ignored();
        bit ok, all_ok;
        clear_capture();
        add_preamble(); add_byte(8'h11); add_byte(8'h22); add_byte(8'h44);
        pulse_start();
        all_ok = 1'b1;
        push_byte(8'h11, ok); all_ok &= ok;
        repeat (6) @(posedge clk);
        #1;
        pulse_start();
        push_byte(8'h22, ok); all_ok &= ok;
        pulse_start();
        push_byte(8'h44, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        repeat (40) @(negedge clk);
        vectors++;
        if (all_ok !== 1'b1 || sym_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL start_ignored_count: ok %b count %0d want 1 %0d",
                                     all_ok, sym_q.size(), exp_q.size());
        end
        vectors++;
        if (fd_count !== 1 || busy !== 1'b0 || glitch !== 0) begin
            miscompares++; $display("FAIL start_ignored_end: done %0d busy %b glitches %0d want 1 0 0",
                                     fd_count, busy, glitch);
        end
    endtask

`ifdef QPSK_PREAMBLE_EN
    // in_ready stays low through the 8-symbol preamble, then FETCH raises it
    task automatic test_preamble();
        bit ok;
        int early;
        clear_capture();
        pulse_start();
        early = 0;
        for (int i = 0; i < 8 * SYM; i++) begin
            @(negedge clk);
            if (in_ready) early++;
        end
        @(negedge clk);
        vectors++;
        if (early !== 0 || in_ready !== 1'b1 || sym_q.size() !== 8) begin
            miscompares++; $display("FAIL preamble: early %0d in_ready %b symbols %0d want 0 1 8",
                                     early, in_ready, sym_q.size());
        end
        push_byte(8'h00, ok); push_byte(8'h00, ok); push_byte(8'h00, ok);
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL preamble_frame: got %b want 1", ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_reset_mid();
        test_start_ignored();
`ifdef QPSK_PREAMBLE_EN
        test_preamble();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
